// File: rtl/ps2_pkg.sv
// Shared types, scan-code set 2 constants and key-mapping helpers for the
// PS/2 keyboard receiver.
package ps2_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } frame_state_e;

  // Set-2 prefixes and special bytes
  localparam logic [7:0] SC_BRK   = 8'hF0;
  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_BAT   = 8'hAA;

  // Set-2 make codes of the mapped keys
  localparam logic [7:0] SC_W     = 8'h1D;
  localparam logic [7:0] SC_A     = 8'h1C;
  localparam logic [7:0] SC_D     = 8'h23;
  localparam logic [7:0] SC_S     = 8'h1B;
  localparam logic [7:0] SC_SPACE = 8'h29;
  localparam logic [7:0] SC_ENTER = 8'h5A;

  // HID usage codes
  localparam logic [7:0] HID_NONE  = 8'h00;
  localparam logic [7:0] HID_W     = 8'h1A;
  localparam logic [7:0] HID_A     = 8'h04;
  localparam logic [7:0] HID_D     = 8'h07;
  localparam logic [7:0] HID_S     = 8'h16;
  localparam logic [7:0] HID_SPACE = 8'h2C;
  localparam logic [7:0] HID_ENTER = 8'h28;

  // Bit positions within the held-key mask
  localparam int IDX_W     = 0;
  localparam int IDX_A     = 1;
  localparam int IDX_D     = 2;
  localparam int IDX_S     = 3;
  localparam int IDX_SPACE = 4;
  localparam int IDX_ENTER = 5;
  localparam int NUM_KEYS  = 6;

  typedef struct packed {
    logic                hit;
    logic [NUM_KEYS-1:0] mask;
    logic [7:0]          hid;
  } keymap_t;

  // Translate a set-2 code into {hit, one-hot held bit, HID code}
  function automatic keymap_t map_code(input logic [7:0] code);
    keymap_t m;
    m = '{hit: 1'b0, mask: '0, hid: HID_NONE};
    case (code)
      SC_W:     m = '{hit: 1'b1, mask: NUM_KEYS'(1) << IDX_W,     hid: HID_W};
      SC_A:     m = '{hit: 1'b1, mask: NUM_KEYS'(1) << IDX_A,     hid: HID_A};
      SC_D:     m = '{hit: 1'b1, mask: NUM_KEYS'(1) << IDX_D,     hid: HID_D};
      SC_S:     m = '{hit: 1'b1, mask: NUM_KEYS'(1) << IDX_S,     hid: HID_S};
      SC_SPACE: m = '{hit: 1'b1, mask: NUM_KEYS'(1) << IDX_SPACE, hid: HID_SPACE};
      SC_ENTER: m = '{hit: 1'b1, mask: NUM_KEYS'(1) << IDX_ENTER, hid: HID_ENTER};
      default:  m = '{hit: 1'b0, mask: '0, hid: HID_NONE};
    endcase
    return m;
  endfunction

  // HID code of a held-mask bit position
  function automatic logic [7:0] idx_hid(input int idx);
    logic [7:0] h;
    case (idx)
      IDX_W:     h = HID_W;
      IDX_A:     h = HID_A;
      IDX_D:     h = HID_D;
      IDX_S:     h = HID_S;
      IDX_SPACE: h = HID_SPACE;
      IDX_ENTER: h = HID_ENTER;
      default:   h = HID_NONE;
    endcase
    return h;
  endfunction

  // HID code of the lowest-index held key, or none
  function automatic logic [7:0] lowest_hid(input logic [NUM_KEYS-1:0] held);
    logic [7:0] h;
    h = HID_NONE;
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (held[i]) h = idx_hid(i);
    end
    return h;
  endfunction

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 frame receiver: pin synchronizers, clock glitch filter, 11-bit frame
// FSM with parity/stop checking and an inactivity timeout.
module ps2_frame_rx
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 10000
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       ps2_clk_i,
  input  logic       ps2_dat_i,
  output logic [7:0] rx_byte_o,
  output logic       rx_valid_o,
  output logic       frame_err_o
);

  localparam int FCW = $clog2(FILTER_LEN + 1);
  localparam int TOW = $clog2(TIMEOUT_CYCLES + 1);

  logic [1:0]     clk_sync_q, dat_sync_q;
  logic           filt_q, filt_d;
  logic [FCW-1:0] fcnt_q, fcnt_d;
  logic           strobe;
  logic           dat;

  frame_state_e   state_q, state_d;
  logic [2:0]     bitcnt_q, bitcnt_d;
  logic [7:0]     shift_q, shift_d;
  logic           par_q, par_d;
  logic [TOW-1:0] tocnt_q, tocnt_d;
  logic [7:0]     rx_byte_q, rx_byte_d;
  logic           rx_valid_q, rx_valid_d;
  logic           err_q, err_d;

  // Two-flop synchronizers; idle-high lines reset to 1 so no false edge appears
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      clk_sync_q <= 2'b11;
      dat_sync_q <= 2'b11;
    end else begin
      clk_sync_q <= {clk_sync_q[0], ps2_clk_i};
      dat_sync_q <= {dat_sync_q[0], ps2_dat_i};
    end
  end

  assign dat = dat_sync_q[1];

  // Filtered clock flips only after FILTER_LEN consecutive disagreeing samples
  always_comb begin
    filt_d = filt_q;
    fcnt_d = '0;
    if (clk_sync_q[1] != filt_q) begin
      if (fcnt_q == FCW'(FILTER_LEN - 1)) begin
        filt_d = clk_sync_q[1];
      end else begin
        fcnt_d = fcnt_q + FCW'(1);
      end
    end
  end

  // A falling edge of the filtered clock is the bit-sample strobe
  assign strobe = filt_q & ~filt_d;

  // Filter state
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      filt_q <= 1'b1;
      fcnt_q <= '0;
    end else begin
      filt_q <= filt_d;
      fcnt_q <= fcnt_d;
    end
  end

  // Frame FSM next-state, timeout and result strobes
  always_comb begin
    state_d    = state_q;
    bitcnt_d   = bitcnt_q;
    shift_d    = shift_q;
    par_d      = par_q;
    tocnt_d    = '0;
    rx_byte_d  = rx_byte_q;
    rx_valid_d = 1'b0;
    err_d      = 1'b0;

    // Inactivity timeout: only while a frame is in progress, reset by each strobe
    if (state_q != ST_IDLE && !strobe) begin
      if (tocnt_q == TOW'(TIMEOUT_CYCLES - 1)) begin
        err_d   = 1'b1;
        state_d = ST_IDLE;
      end else begin
        tocnt_d = tocnt_q + TOW'(1);
      end
    end

    if (strobe) begin
      case (state_q)
        ST_IDLE: begin
          if (!dat) begin
            state_d  = ST_DATA;
            bitcnt_d = '0;
          end
        end
        ST_DATA: begin
          shift_d  = {dat, shift_q[7:1]};
          bitcnt_d = bitcnt_q + 3'd1;
          if (bitcnt_q == 3'd7) state_d = ST_PARITY;
        end
        ST_PARITY: begin
          par_d   = dat;
          state_d = ST_STOP;
        end
        ST_STOP: begin
          if (dat && (^{shift_q, par_q})) begin
            rx_byte_d  = shift_q;
            rx_valid_d = 1'b1;
          end else begin
            err_d = 1'b1;
          end
          state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Frame FSM state and output registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ST_IDLE;
      bitcnt_q   <= '0;
      shift_q    <= '0;
      par_q      <= 1'b0;
      tocnt_q    <= '0;
      rx_byte_q  <= '0;
      rx_valid_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      bitcnt_q   <= bitcnt_d;
      shift_q    <= shift_d;
      par_q      <= par_d;
      tocnt_q    <= tocnt_d;
      rx_byte_q  <= rx_byte_d;
      rx_valid_q <= rx_valid_d;
      err_q      <= err_d;
    end
  end

  assign rx_byte_o   = rx_byte_q;
  assign rx_valid_o  = rx_valid_q;
  assign frame_err_o = err_q;

endmodule

// File: rtl/ps2_keycode_rx.sv
// PS/2 set-2 keyboard receiver producing the HID keycode of the most recent
// held movement/menu key, plus the held-key mask and raw-byte diagnostics.
module ps2_keycode_rx
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 10000
) (
  input  logic       clk_50,
  input  logic       Reset_n,
  input  logic       PS2_CLK,
  input  logic       PS2_DAT,
  output logic [7:0] keycode,
  output logic [5:0] held,
  output logic       key_event,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  output logic       frame_err
);

  logic                brk_q, brk_d;
  logic                ext_q, ext_d;
  logic [NUM_KEYS-1:0] held_q, held_d;
  logic [7:0]          kc_q, kc_d;
  logic                ev_q, ev_d;
  keymap_t             m;

  ps2_frame_rx #(
    .FILTER_LEN    (FILTER_LEN),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_frame (
    .clk_i      (clk_50),
    .rst_ni     (Reset_n),
    .ps2_clk_i  (PS2_CLK),
    .ps2_dat_i  (PS2_DAT),
    .rx_byte_o  (rx_byte),
    .rx_valid_o (rx_valid),
    .frame_err_o(frame_err)
  );

  assign m = map_code(rx_byte);

  // Make/break decoder: prefix flags, held mask and most-recent keycode
  always_comb begin
    brk_d  = brk_q;
    ext_d  = ext_q;
    held_d = held_q;
    kc_d   = kc_q;
    ev_d   = 1'b0;
    if (rx_valid) begin
      if (rx_byte == SC_BRK) begin
        brk_d = 1'b1;
      end else if (rx_byte == SC_EXT) begin
        ext_d = 1'b1;
      end else begin
        brk_d = 1'b0;
        ext_d = 1'b0;
        // Extended codes (E0 xx) share numbers with the mapped keys; drop them
        if (!ext_q) begin
          if (rx_byte == SC_BAT && !brk_q) begin
            held_d = '0;
            kc_d   = HID_NONE;
          end else if (m.hit) begin
            if (!brk_q) begin
              held_d = held_q | m.mask;
              kc_d   = m.hid;
              ev_d   = 1'b1;
            end else if ((held_q & m.mask) != '0) begin
              held_d = held_q & ~m.mask;
              if (kc_q == m.hid) kc_d = lowest_hid(held_d);
            end
          end
        end
      end
    end
  end

  // Decoder registers
  always_ff @(posedge clk_50 or negedge Reset_n) begin
    if (!Reset_n) begin
      brk_q  <= 1'b0;
      ext_q  <= 1'b0;
      held_q <= '0;
      kc_q   <= HID_NONE;
      ev_q   <= 1'b0;
    end else begin
      brk_q  <= brk_d;
      ext_q  <= ext_d;
      held_q <= held_d;
      kc_q   <= kc_d;
      ev_q   <= ev_d;
    end
  end

  assign keycode   = kc_q;
  assign held      = held_q;
  assign key_event = ev_q;

endmodule

// File: tb/tb_ps2_keycode_rx.sv
// Directed testbench for ps2_keycode_rx: drives PS/2 frames on the pins and
// checks keycode/held/diagnostic outputs against hand-computed values.
module tb_ps2_keycode_rx;

  // PS/2 half bit period in clk_50 cycles (2 us bit period keeps the run short)
  localparam int HALF = 50;

  logic       clk_50 = 1'b0;
  logic       Reset_n;
  logic       PS2_CLK;
  logic       PS2_DAT;
  logic [7:0] keycode;
  logic [5:0] held;
  logic       key_event;
  logic [7:0] rx_byte;
  logic       rx_valid;
  logic       frame_err;

  int nvec = 0;
  int nmis = 0;

  int cyc = 0;
  int n_rxv = 0, n_err = 0, n_ev = 0;
  int ev_cyc = 0, stb_cyc = 0;
  logic [7:0] last_rx = 8'h00;

  int b_rxv, b_err, b_ev;

  ps2_keycode_rx #(
    .FILTER_LEN    (8),
    .TIMEOUT_CYCLES(10000)
  ) u_dut (
    .clk_50   (clk_50),
    .Reset_n  (Reset_n),
    .PS2_CLK  (PS2_CLK),
    .PS2_DAT  (PS2_DAT),
    .keycode  (keycode),
    .held     (held),
    .key_event(key_event),
    .rx_byte  (rx_byte),
    .rx_valid (rx_valid),
    .frame_err(frame_err)
  );

  always #10 clk_50 = ~clk_50;

  always @(posedge clk_50) cyc <= cyc + 1;

  // Event monitor, sampled away from the active edge
  always @(negedge clk_50) begin
    if (u_dut.u_frame.strobe) stb_cyc <= cyc;
    if (rx_valid) begin
      n_rxv   <= n_rxv + 1;
      last_rx <= rx_byte;
    end
    if (frame_err) n_err <= n_err + 1;
    if (key_event) begin
      n_ev   <= n_ev + 1;
      ev_cyc <= cyc;
    end
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nmis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk_50);
  endtask

  task automatic snap();
    b_rxv = n_rxv;
    b_err = n_err;
    b_ev  = n_ev;
  endtask

  // One PS/2 bit: data set while clock high, clock low for HALF cycles.
  // With g set, short pulses (shorter than the filter) are added in both phases.
  task automatic ps2_bit(input logic b, input logic g);
    PS2_DAT = b;
    wait_cyc(10);
    if (g) begin
      PS2_CLK = 1'b0; wait_cyc(4); PS2_CLK = 1'b1;
    end
    wait_cyc(HALF / 2 - 10);
    PS2_CLK = 1'b0;
    wait_cyc(20);
    if (g) begin
      PS2_CLK = 1'b1; wait_cyc(4); PS2_CLK = 1'b0;
    end
    wait_cyc(HALF - 20);
    PS2_CLK = 1'b1;
    wait_cyc(HALF / 2);
  endtask

  // Full or truncated frame: start, nbits data bits (LSB first), parity, stop
  task automatic send_frame(input logic [7:0] b, input logic par_ok, input logic stop,
                            input int nbits, input logic g);
    logic par;
    par = par_ok ? ~(^b) : (^b);
    ps2_bit(1'b0, g);
    for (int i = 0; i < nbits; i++) ps2_bit(b[i], g);
    if (nbits == 8) begin
      ps2_bit(par, g);
      ps2_bit(stop, g);
      PS2_DAT = 1'b1;
      wait_cyc(20);
    end
  endtask

  task automatic send(input logic [7:0] b);
    send_frame(b, 1'b1, 1'b1, 8, 1'b0);
  endtask

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation did not complete, cyc=%0d", cyc);
    $fatal(1);
  end

  initial begin
    Reset_n = 1'b0;
    PS2_CLK = 1'b1;
    PS2_DAT = 1'b1;
    wait_cyc(5);
    check_val("rst_keycode", 32'(keycode), 32'h00);
    check_val("rst_held", 32'(held), 32'h00);
    check_val("rst_key_event", 32'(key_event), 32'h0);
    check_val("rst_rx_byte", 32'(rx_byte), 32'h00);
    check_val("rst_rx_valid", 32'(rx_valid), 32'h0);
    check_val("rst_frame_err", 32'(frame_err), 32'h0);
    Reset_n = 1'b1;
    wait_cyc(20);

    // Make A
    snap();
    send(8'h1C);
    check_val("a_rxv_cnt", 32'(n_rxv - b_rxv), 32'd1);
    check_val("a_rx_byte", 32'(last_rx), 32'h1C);
    check_val("a_keycode", 32'(keycode), 32'h04);
    check_val("a_held", 32'(held), 32'b000010);
    check_val("a_event_cnt", 32'(n_ev - b_ev), 32'd1);
    check_val("a_latency", 32'(ev_cyc - stb_cyc), 32'd2);

    // Make D, break D, break A
    snap();
    send(8'h23);
    check_val("d_keycode", 32'(keycode), 32'h07);
    check_val("d_held", 32'(held), 32'b000110);
    send(8'hF0); send(8'h23);
    check_val("brk_d_keycode", 32'(keycode), 32'h04);
    check_val("brk_d_held", 32'(held), 32'b000010);
    check_val("brk_d_events", 32'(n_ev - b_ev), 32'd1);
    send(8'hF0); send(8'h1C);
    check_val("brk_a_keycode", 32'(keycode), 32'h00);
    check_val("brk_a_held", 32'(held), 32'h00);

    // Bad parity, then bad stop bit
    snap();
    send_frame(8'h1D, 1'b0, 1'b1, 8, 1'b0);
    check_val("par_err_cnt", 32'(n_err - b_err), 32'd1);
    check_val("par_rxv_cnt", 32'(n_rxv - b_rxv), 32'd0);
    check_val("par_keycode", 32'(keycode), 32'h00);
    snap();
    send_frame(8'h1D, 1'b1, 1'b0, 8, 1'b0);
    check_val("stop_err_cnt", 32'(n_err - b_err), 32'd1);
    check_val("stop_rxv_cnt", 32'(n_rxv - b_rxv), 32'd0);

    // Stall after 4 data bits until the timeout fires
    snap();
    send_frame(8'h1B, 1'b1, 1'b1, 4, 1'b0);
    wait_cyc(10100);
    check_val("to_err_cnt", 32'(n_err - b_err), 32'd1);
    check_val("to_rxv_cnt", 32'(n_rxv - b_rxv), 32'd0);
    check_val("to_state_idle", 32'(u_dut.u_frame.state_q), 32'd0);
    send(8'h1B);
    check_val("s_keycode", 32'(keycode), 32'h16);
    check_val("s_held", 32'(held), 32'b001000);

    // Extended codes are ignored
    snap();
    send(8'hE0); send(8'h1D);
    check_val("ext_make_keycode", 32'(keycode), 32'h16);
    check_val("ext_make_held", 32'(held), 32'b001000);
    send(8'hE0); send(8'hF0); send(8'h1D);
    check_val("ext_brk_keycode", 32'(keycode), 32'h16);
    check_val("ext_brk_held", 32'(held), 32'b001000);
    check_val("ext_events", 32'(n_ev - b_ev), 32'd0);
    send(8'h29);
    check_val("space_keycode", 32'(keycode), 32'h2C);
    check_val("space_held", 32'(held), 32'b011000);

    // Enter with short clock glitches in every bit
    snap();
    send_frame(8'h5A, 1'b1, 1'b1, 8, 1'b1);
    check_val("glitch_rxv_cnt", 32'(n_rxv - b_rxv), 32'd1);
    check_val("glitch_rx_byte", 32'(last_rx), 32'h5A);
    check_val("glitch_err_cnt", 32'(n_err - b_err), 32'd0);
    check_val("enter_keycode", 32'(keycode), 32'h28);
    check_val("enter_held", 32'(held), 32'b111000);

    // Typematic repeat pulses again
    snap();
    send(8'h5A);
    check_val("repeat_events", 32'(n_ev - b_ev), 32'd1);
    check_val("repeat_keycode", 32'(keycode), 32'h28);

    // Break Enter falls back to the lowest held key (S)
    send(8'hF0); send(8'h5A);
    check_val("fallback_keycode", 32'(keycode), 32'h16);
    check_val("fallback_held", 32'(held), 32'b011000);

    // Break of a key not held changes nothing
    send(8'hF0); send(8'h1C);
    check_val("brk_unheld_keycode", 32'(keycode), 32'h16);
    check_val("brk_unheld_held", 32'(held), 32'b011000);

    // BAT clears everything
    send(8'hAA);
    check_val("bat_keycode", 32'(keycode), 32'h00);
    check_val("bat_held", 32'(held), 32'h00);

    // Make W, then reset in the middle of the next frame
    send(8'h1D);
    check_val("w_keycode", 32'(keycode), 32'h1A);
    check_val("w_held", 32'(held), 32'b000001);
    send_frame(8'h1C, 1'b1, 1'b1, 3, 1'b0);
    Reset_n = 1'b0;
    #1;
    check_val("midrst_keycode", 32'(keycode), 32'h00);
    check_val("midrst_held", 32'(held), 32'h00);
    check_val("midrst_rx_byte", 32'(rx_byte), 32'h00);
    check_val("midrst_key_event", 32'(key_event), 32'h0);
    PS2_CLK = 1'b1;
    PS2_DAT = 1'b1;
    wait_cyc(5);
    Reset_n = 1'b1;
    wait_cyc(20);
    snap();
    send(8'h1C);
    check_val("post_rst_rx_byte", 32'(last_rx), 32'h1C);
    check_val("post_rst_err_cnt", 32'(n_err - b_err), 32'd0);
    check_val("post_rst_keycode", 32'(keycode), 32'h04);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
